// File: rtl/level_seq_ctl_if.sv
// Purpose: bundles the sequencer's game-control, map-ROM and status signals.
// Latency: none, wiring only.
// Backpressure: none; level-sensitive and pulse signals, no handshake.
interface level_seq_ctl_if #(
    parameter int TILES = 150
);
    logic                 start;
    logic                 level_done;
    logic                 add_time;
    logic [9:0]           rom_addr;
    logic [3:0]           rom_data;
    logic [TILES*4-1:0]   map;
    logic                 next_level;
    logic [2:0]           level;
    logic [7:0]           time_left;
    logic                 running;
    logic                 game_over;
    logic                 game_won;

    // Sequencer side
    modport master (
        input  start, level_done, add_time, rom_data,
        output rom_addr, map, next_level, level, time_left,
               running, game_over, game_won
    );

    // Game logic / ROM / map unit side
    modport slave (
        output start, level_done, add_time, rom_data,
        input  rom_addr, map, next_level, level, time_left,
               running, game_over, game_won
    );
endinterface

// File: rtl/level_seq_ctl.sv
// Purpose: loads a level map from ROM, arms the map unit, runs the level countdown.
// Latency: LOAD takes TILES+1 cycles, ARM 1 cycle; all outputs registered.
// Backpressure: none; ROM is fixed 1-cycle latency, inputs are sampled every cycle.
module level_seq_ctl #(
    parameter int TILES        = 150,
    parameter int NUM_LEVELS   = 4,
    parameter int TICK_DIV     = 65000000,
    parameter int LEVEL_TIME   = 60,
    parameter int ADD_TIME_SEC = 10
) (
    input  logic            clk,
    input  logic            rst,
    level_seq_ctl_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;
    localparam logic [2:0] S_WIN  = 3'd5;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(TILES + 1);

    logic [2:0]         r_state;
    logic [IW-1:0]      r_tile;
    logic [TW-1:0]      r_tick;
    logic               r_add_prev;
    logic [9:0]         r_rom_addr;
    logic [TILES*4-1:0] r_map;
    logic               r_next_level;
    logic [2:0]         r_level;
    logic [7:0]         r_time;
    logic               r_running;
    logic               r_game_over;
    logic               r_game_won;

    logic               w_add_evt;
    logic               w_tick;
    logic               w_last_level;
    logic [IW-1:0]      w_wr_idx;
    logic [9:0]         w_time_sum;
    logic [7:0]         w_time_nxt;
    logic               w_load_go;
    logic [2:0]         w_load_lvl;

    // First ROM word of a level's block
    function automatic logic [9:0] f_base(input logic [2:0] lvl);
        f_base = 10'(int'(lvl) * TILES);
    endfunction

    assign w_add_evt    = bus.add_time & ~r_add_prev;
    assign w_tick       = (r_tick == TW'(TICK_DIV - 1));
    assign w_last_level = (r_level == 3'(NUM_LEVELS - 1));
    // ROM data arriving now belongs to the address issued one cycle earlier
    assign w_wr_idx     = r_tile - IW'(1);

    // Next countdown value: add/tick combined, clamped to 0..255
    always_comb begin
        w_time_sum = {2'b00, r_time}
                   + (w_add_evt ? 10'(ADD_TIME_SEC) : 10'd0)
                   - (w_tick    ? 10'd1             : 10'd0);
        if (w_time_sum[9]) begin
            w_time_nxt = 8'd0;
        end else if (w_time_sum > 10'd255) begin
            w_time_nxt = 8'hFF;
        end else begin
            w_time_nxt = w_time_sum[7:0];
        end
    end

    // Decide whether a map load starts this cycle and for which level
    always_comb begin
        w_load_go  = 1'b0;
        w_load_lvl = r_level;
        case (r_state)
            S_IDLE, S_OVER, S_WIN: begin
                if (bus.start) begin
                    w_load_go  = 1'b1;
                    w_load_lvl = 3'd0;
                end
            end
            S_PLAY: begin
                if (bus.level_done && !w_last_level) begin
                    w_load_go  = 1'b1;
                    w_load_lvl = r_level + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer state, map shift-in, countdown and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tile       <= '0;
            r_tick       <= '0;
            r_add_prev   <= 1'b0;
            r_rom_addr   <= '0;
            r_map        <= '0;
            r_next_level <= 1'b0;
            r_level      <= '0;
            r_time       <= '0;
            r_running    <= 1'b0;
            r_game_over  <= 1'b0;
            r_game_won   <= 1'b0;
        end else begin
            r_add_prev   <= bus.add_time;
            r_next_level <= 1'b0;

            // Countdown keeps running on the cycle a level ends
            if (r_state == S_PLAY) begin
                r_time <= w_time_nxt;
                r_tick <= w_tick ? '0 : r_tick + TW'(1);
            end

            if (w_load_go) begin
                r_state     <= S_LOAD;
                r_level     <= w_load_lvl;
                r_tile      <= '0;
                r_map       <= '0;
                r_rom_addr  <= f_base(w_load_lvl);
                r_running   <= 1'b0;
                r_game_over <= 1'b0;
                r_game_won  <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_tile <= r_tile + IW'(1);
                        if (r_tile != '0) begin
                            r_map[4*int'(w_wr_idx) +: 4] <= bus.rom_data;
                        end
                        if (r_tile == IW'(TILES)) begin
                            r_state      <= S_ARM;
                            r_next_level <= 1'b1;
                        end else if (r_tile < IW'(TILES - 1)) begin
                            r_rom_addr <= r_rom_addr + 10'd1;
                        end
                    end
                    S_ARM: begin
                        r_time    <= 8'(LEVEL_TIME);
                        r_tick    <= '0;
                        r_running <= 1'b1;
                        r_state   <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (bus.level_done) begin
                            r_state    <= S_WIN;
                            r_running  <= 1'b0;
                            r_game_won <= 1'b1;
                        end else if (w_time_nxt == 8'd0) begin
                            r_state     <= S_OVER;
                            r_running   <= 1'b0;
                            r_game_over <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.map        = r_map;
    assign bus.next_level = r_next_level;
    assign bus.level      = r_level;
    assign bus.time_left  = r_time;
    assign bus.running    = r_running;
    assign bus.game_over  = r_game_over;
    assign bus.game_won   = r_game_won;
endmodule

// File: tb/tb_level_seq_ctl.sv
// Purpose: checks level_seq_ctl against a phase-level model every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_level_seq_ctl;
    localparam int TILES = 150;
    localparam int NL    = 2;
    localparam int TD    = 4;
    localparam int LT    = 3;
    localparam int ADD   = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    level_seq_ctl_if #(.TILES(TILES)) bus();

    level_seq_ctl #(
        .TILES(TILES), .NUM_LEVELS(NL), .TICK_DIV(TD),
        .LEVEL_TIME(LT), .ADD_TIME_SEC(ADD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Map ROM: word = address mod 5, one cycle latency
    always @(posedge clk) bus.rom_data <= 4'(bus.rom_addr % 10'd5);

    int total  = 0;
    int bad    = 0;
    int nl_cnt = 0;

    // Model: phase 0 IDLE,1 LOAD,2 ARM,3 PLAY,4 OVER,5 WIN
    int m_phase = 0;
    int m_level = 0;
    int m_time  = 0;
    int m_cnt   = 0;
    int m_pc    = 0;
    int m_addr  = 0;
    bit m_prev  = 1'b0;
    int m_tiles [TILES];

    task automatic m_begin_load(input int l);
        m_phase = 1;
        m_level = l;
        m_cnt   = 0;
        m_addr  = l * TILES;
        foreach (m_tiles[i]) m_tiles[i] = 0;
    endtask

    always @(posedge clk) begin : model
        bit ae;
        bit tk;
        int t;
        int base;
        if (!rst) begin
            m_phase = 0; m_level = 0; m_time = 0; m_cnt = 0;
            m_pc = 0; m_addr = 0; m_prev = 1'b0;
            foreach (m_tiles[i]) m_tiles[i] = 0;
        end else begin
            ae = bus.add_time && !m_prev;
            m_prev = bus.add_time;
            case (m_phase)
                0: if (bus.start) m_begin_load(0);
                1: begin
                    base = m_level * TILES;
                    if (m_cnt >= 1) m_tiles[m_cnt-1] = (base + m_cnt - 1) % 5;
                    if (m_cnt == TILES) begin
                        m_phase = 2;
                    end else begin
                        m_cnt++;
                        m_addr = base + ((m_cnt < TILES) ? m_cnt : TILES - 1);
                    end
                end
                2: begin
                    m_time = LT; m_pc = 0; m_phase = 3;
                end
                3: begin
                    tk = (m_pc % TD) == TD - 1;
                    m_pc++;
                    t = m_time + (ae ? ADD : 0) - (tk ? 1 : 0);
                    if (t > 255) t = 255;
                    if (t < 0) t = 0;
                    m_time = t;
                    if (bus.level_done) begin
                        if (m_level < NL - 1) m_begin_load(m_level + 1);
                        else m_phase = 5;
                    end else if (m_time == 0) begin
                        m_phase = 4;
                    end
                end
                default: if (bus.start) m_begin_load(0);
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chk_map(input string nm, input logic [TILES*4-1:0] a, input logic [TILES*4-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, a, e, $time);
        end
    endtask

    // One cycle: sample outputs mid-cycle and compare with the model
    task automatic step();
        logic [TILES*4-1:0] em;
        @(negedge clk);
        for (int i = 0; i < TILES; i++) em[4*i +: 4] = 4'(m_tiles[i]);
        chk("rom_addr",   32'(bus.rom_addr),   m_addr);
        chk("level",      32'(bus.level),      m_level);
        chk("time_left",  32'(bus.time_left),  m_time);
        chk("next_level", 32'(bus.next_level), 32'(m_phase == 2));
        chk("running",    32'(bus.running),    32'(m_phase == 3));
        chk("game_over",  32'(bus.game_over),  32'(m_phase == 4));
        chk("game_won",   32'(bus.game_won),   32'(m_phase == 5));
        chk_map("map", bus.map, em);
        if (bus.next_level === 1'b1) nl_cnt++;
    endtask

    task automatic wait_nl(output int n);
        n = 0;
        while (bus.next_level !== 1'b1 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (bus.running !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("run_seen", 32'(bus.running), 1);
    endtask

    initial begin
        int n;
        int c;
        bus.start = 1'b0; bus.level_done = 1'b0; bus.add_time = 1'b0;
        rst = 1'b0;
        step(); step(); step();
        chk("rst_level",   32'(bus.level), 0);
        chk("rst_time",    32'(bus.time_left), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk_map("rst_map", bus.map, '0);
        rst = 1'b1;
        step();

        // First load of level 0
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("load_addr0", 32'(bus.rom_addr), 0);
        wait_nl(n);
        chk("nl_latency", n, 151);
        chk("tile0",   32'(bus.map[3:0]), 0);
        chk("tile1",   32'(bus.map[7:4]), 1);
        chk("tile149", 32'(bus.map[599:596]), 4);
        chk("addr_last", 32'(bus.rom_addr), 149);
        chk("nl_cnt1", nl_cnt, 1);
        step();
        chk("arm_time", 32'(bus.time_left), 3);
        chk("arm_run",  32'(bus.running), 1);

        // Countdown to timeout
        n = 0;
        while (bus.game_over !== 1'b1 && n < 40) begin step(); n++; end
        chk("over_latency", n, 12);
        chk("over_time", 32'(bus.time_left), 0);
        chk("over_run",  32'(bus.running), 0);
        bus.add_time = 1'b1; step(); bus.add_time = 1'b0; step();
        chk("over_add_ignored", 32'(bus.time_left), 0);

        // Add-time pickups
        bus.start = 1'b1; step(); bus.start = 1'b0;
        wait_run();
        repeat (4) step();
        chk("p4_time", 32'(bus.time_left), 2);
        bus.add_time = 1'b1; step();
        chk("add_2_to_12", 32'(bus.time_left), 12);
        bus.add_time = 1'b0; step(); step();
        bus.add_time = 1'b1; step();
        chk("add_on_tick_21", 32'(bus.time_left), 21);
        repeat (18) step();
        chk("held_adds_once", 32'(bus.time_left), 17);
        bus.add_time = 1'b0;
        repeat (29) begin
            step(); bus.add_time = 1'b1; step(); bus.add_time = 1'b0;
        end
        step(); bus.add_time = 1'b1; step();
        chk("saturate", 32'(bus.time_left), 255);
        bus.add_time = 1'b0;
        n = 0;
        while (bus.time_left !== 8'd250 && n < 60) begin step(); n++; end
        chk("reach_250", 32'(bus.time_left), 250);
        bus.add_time = 1'b1; step();
        chk("add_250_sat", 32'(bus.time_left), 255);
        bus.add_time = 1'b0;
        repeat (200) begin
            bus.add_time = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.add_time = 1'b0; step();

        // Level advance
        bus.level_done = 1'b1; step(); bus.level_done = 1'b0;
        wait_nl(n);
        chk("lvl1_nl_latency", n, 151);
        chk("lvl1_level", 32'(bus.level), 1);
        chk("lvl1_addr_last", 32'(bus.rom_addr), 299);
        chk("nl_cnt3", nl_cnt, 3);
        step();
        bus.add_time = 1'b1; step();
        repeat (40) begin
            if (bus.time_left < 8'd4) bus.add_time = !bus.add_time;
            else bus.add_time = 1'($urandom_range(0, 1));
            step();
        end
        bus.add_time = 1'b0; step();
        bus.level_done = 1'b1; step(); bus.level_done = 1'b0;
        chk("won",       32'(bus.game_won), 1);
        chk("won_level", 32'(bus.level), 1);
        repeat (3) step();
        chk("won_hold", 32'(bus.game_won), 1);

        // Restart from WIN
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("restart_level", 32'(bus.level), 0);
        chk_map("restart_clear", bus.map, '0);
        wait_nl(n);
        chk("reload_latency", n, 151);
        chk("reload_addr_last", 32'(bus.rom_addr), 149);
        step();

        // level_done on the cycle time reaches 0
        repeat (11) step();
        chk("pre_zero_time", 32'(bus.time_left), 1);
        bus.level_done = 1'b1; step(); bus.level_done = 1'b0;
        chk("sim_level", 32'(bus.level), 1);
        chk("sim_over",  32'(bus.game_over), 0);
        chk("sim_time",  32'(bus.time_left), 0);

        // Reset in the middle of LOAD
        repeat (70) step();
        chk("mid_load_addr", 32'(bus.rom_addr), 220);
        rst = 1'b0; step();
        chk("rst2_addr",  32'(bus.rom_addr), 0);
        chk("rst2_level", 32'(bus.level), 0);
        chk("rst2_time",  32'(bus.time_left), 0);
        chk_map("rst2_map", bus.map, '0);
        rst = 1'b1;
        c = nl_cnt;
        repeat (200) step();
        chk("no_nl_after_rst", nl_cnt, c);
        chk("idle_not_running", 32'(bus.running), 0);
        chk("nl_total", nl_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
